// File: rtl/bg_render_pkg.sv
// Shared types and constants for the background renderer: fade states, level range and channel scaling.
package bg_render_pkg;

  typedef enum logic [1:0] {
    DARK     = 2'd0,
    FADE_IN  = 2'd1,
    BRIGHT   = 2'd2,
    FADE_OUT = 2'd3
  } fade_state_t;

  localparam int LEVEL_W     = 5;
  localparam int LEVEL_MAX   = 16;
  localparam int LEVEL_SHIFT = 4;
  localparam int RGB_W       = 4;

  // (c * level) >> 4 with level in 0..16; level 16 is an exact passthrough.
  function automatic logic [RGB_W-1:0] scale_channel(input logic [RGB_W-1:0]   c,
                                                     input logic [LEVEL_W-1:0] level);
    return RGB_W'(({{LEVEL_W{1'b0}}, c} * {{RGB_W{1'b0}}, level}) >> LEVEL_SHIFT);
  endfunction

endpackage

// File: rtl/bg_fade_ctrl.sv
// Frame-stepped fade controller: DARK/FADE_IN/BRIGHT/FADE_OUT with a 0..16 brightness level.
// Only instantiated when BG_FADE_EN is defined.
module bg_fade_ctrl
  import bg_render_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               i_frame_tick,
  input  logic               i_fade_in,
  input  logic               i_fade_out,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_fade_busy,
  output logic               o_fade_done
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [LEVEL_W-1:0] LVL_TOP  = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LVL_NEAR = LEVEL_W'(LEVEL_MAX - 1);
  localparam logic [LEVEL_W-1:0] LVL_ONE  = LEVEL_W'(1);

  fade_state_t        r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LEVEL_W-1:0] r_level;
  logic               r_done;

  logic w_ramping;
  logic w_accept_out;
  logic w_accept_in;

  assign w_ramping    = (r_state == FADE_IN) || (r_state == FADE_OUT);
  // fade_out is checked first so it wins when both commands arrive together.
  assign w_accept_out = i_fade_out && (r_state != DARK);
  assign w_accept_in  = i_fade_in && (r_state != BRIGHT);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state <= DARK;
      r_cnt   <= '0;
      r_level <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept_out) begin
        r_state <= FADE_OUT;
        r_cnt   <= '0;
      end else if (w_accept_in) begin
        r_state <= FADE_IN;
        r_cnt   <= '0;
      end else if (i_frame_tick && w_ramping) begin
        if (r_cnt == CNT_LAST) begin
          r_cnt <= '0;
          if (r_state == FADE_IN) begin
            if (r_level >= LVL_NEAR) begin
              r_level <= LVL_TOP;
              r_state <= BRIGHT;
              r_done  <= 1'b1;
            end else begin
              r_level <= r_level + LVL_ONE;
            end
          end else begin
            // A reversal at level 0 lands here too, so saturate rather than wrap.
            if (r_level <= LVL_ONE) begin
              r_level <= '0;
              r_state <= DARK;
              r_done  <= 1'b1;
            end else begin
              r_level <= r_level - LVL_ONE;
            end
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_level     = r_level;
  assign o_fade_busy = w_ramping;
  assign o_fade_done = r_done;

endmodule

// File: rtl/bg_fade_renderer.sv
// Scaled full-screen background renderer: DrawX/DrawY -> ROM address, palette colour, brightness fade.
// Define BG_FADE_EN to include the fade controller; otherwise brightness is fixed at full.
module bg_fade_renderer
  import bg_render_pkg::*;
#(
  parameter int SRC_W           = 320,
  parameter int SRC_H           = 240,
  parameter int SCALE_SHIFT     = 1,
  parameter int IDX_W           = 4,
  parameter int ADDR_W          = 17,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_tick,
  input  logic              fade_in,
  input  logic              fade_out,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [11:0]       pal_rgb,
  output logic [RGB_W-1:0]  red,
  output logic [RGB_W-1:0]  green,
  output logic [RGB_W-1:0]  blue,
  output logic              fade_busy,
  output logic              fade_done
);

  localparam logic [10:0]       SRC_W_X = 11'(SRC_W);
  localparam logic [10:0]       SRC_H_Y = 11'(SRC_H);
  localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);

  logic [9:0]         w_xs;
  logic [9:0]         w_ys;
  logic               w_in_range;
  logic [ADDR_W-1:0]  w_addr;
  logic [LEVEL_W-1:0] w_level;

  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_valid_s1;
  logic               r_valid_s2;
  logic [RGB_W-1:0]   r_red;
  logic [RGB_W-1:0]   r_green;
  logic [RGB_W-1:0]   r_blue;

  assign w_xs       = DrawX >> SCALE_SHIFT;
  assign w_ys       = DrawY >> SCALE_SHIFT;
  assign w_in_range = ({1'b0, w_xs} < SRC_W_X) && ({1'b0, w_ys} < SRC_H_Y);
  assign w_addr     = ADDR_W'(w_ys) * SRC_W_A + ADDR_W'(w_xs);

  // Stage 1 drives the ROM address, stage 2 waits on the ROM read, stage 3 registers colour.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_rom_addr <= '0;
      r_valid_s1 <= 1'b0;
      r_valid_s2 <= 1'b0;
      r_red      <= '0;
      r_green    <= '0;
      r_blue     <= '0;
    end else begin
      // NOTE: non-blocking assignments here so each stage sees the previous stage's pre-edge value.
      r_rom_addr <= w_in_range ? w_addr : '0;
      r_valid_s1 <= blank && w_in_range;
      r_valid_s2 <= r_valid_s1;
      r_red      <= r_valid_s2 ? scale_channel(pal_rgb[11:8], w_level) : '0;
      r_green    <= r_valid_s2 ? scale_channel(pal_rgb[7:4],  w_level) : '0;
      r_blue     <= r_valid_s2 ? scale_channel(pal_rgb[3:0],  w_level) : '0;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign pal_index = rom_data;
  assign red       = r_red;
  assign green     = r_green;
  assign blue      = r_blue;

`ifdef BG_FADE_EN
  bg_fade_ctrl #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_fade (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .i_frame_tick(frame_tick),
    .i_fade_in   (fade_in),
    .i_fade_out  (fade_out),
    .o_level     (w_level),
    .o_fade_busy (fade_busy),
    .o_fade_done (fade_done)
  );
`else
  logic w_unused_cmds;

  assign w_level       = LEVEL_W'(LEVEL_MAX);
  assign fade_busy     = 1'b0;
  assign fade_done     = 1'b0;
  assign w_unused_cmds = &{1'b0, frame_tick, fade_in, fade_out};
`endif

endmodule

// File: tb/tb_bg_fade_renderer.sv
// Directed self-checking bench for bg_fade_renderer with a synchronous ROM and palette model.
module tb_bg_fade_renderer;

  localparam int ADDR_W = 17;

  logic              vga_clk    = 1'b0;
  logic              reset      = 1'b1;
  logic [9:0]        DrawX      = '0;
  logic [9:0]        DrawY      = '0;
  logic              blank      = 1'b0;
  logic              frame_tick = 1'b0;
  logic              fade_in    = 1'b0;
  logic              fade_out   = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data   = '0;
  logic [3:0]        pal_index;
  logic [11:0]       pal_rgb;
  logic [3:0]        red;
  logic [3:0]        green;
  logic [3:0]        blue;
  logic              fade_busy;
  logic              fade_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 vga_clk = ~vga_clk;

  bg_fade_renderer #(
    .SRC_W          (320),
    .SRC_H          (240),
    .SCALE_SHIFT    (1),
    .IDX_W          (4),
    .ADDR_W         (ADDR_W),
    .FRAMES_PER_STEP(2)
  ) u_dut (
    .vga_clk   (vga_clk),
    .reset     (reset),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .blank     (blank),
    .frame_tick(frame_tick),
    .fade_in   (fade_in),
    .fade_out  (fade_out),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pal_index (pal_index),
    .pal_rgb   (pal_rgb),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .fade_busy (fade_busy),
    .fade_done (fade_done)
  );

  // ROM model: one-cycle read, index is the low nibble of the address.
  always @(posedge vga_clk) rom_data <= rom_addr[3:0];

  function automatic logic [11:0] pal_lut(input logic [3:0] idx);
    case (idx)
      4'd1:    return 12'hF84;
      4'd5:    return 12'h3C9;
      4'd15:   return 12'hA5E;
      default: return 12'h111;
    endcase
  endfunction

  always_comb pal_rgb = pal_lut(pal_index);

`ifdef BG_FADE_EN
  int n_done = 0;
  always @(posedge vga_clk) if (fade_done) n_done++;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic b);
    DrawX = x;
    DrawY = y;
    blank = b;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_in();
    fade_in = 1'b1;
    tick();
    fade_in = 1'b0;
  endtask

  task automatic pulse_out();
    fade_out = 1'b1;
    tick();
    fade_out = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    pix(10'd2, 10'd2, 1'b1);
    repeat (3) tick();
    chk("reset_addr", 32'(rom_addr), 0);
    chk("reset_rgb", 32'({red, green, blue}), 0);
    chk("reset_busy", 32'(fade_busy), 0);
    chk("reset_done", 32'(fade_done), 0);
    reset = 1'b0;

    // First pixel after reset: address at 1 cycle, colour at 2 cycles.
    tick();
    chk("first_addr", 32'(rom_addr), 321);
    tick();
    chk("first_rgb_lat1", 32'({red, green, blue}), 0);
    tick();
`ifdef BG_FADE_EN
    chk("first_rgb_dark", 32'({red, green, blue}), 0);

    pulse_out();
    tick();
    chk("fade_out_in_dark", 32'(fade_busy), 0);
    pulse_in();
    chk("fade_in_busy", 32'(fade_busy), 1);
    frames(16);
    chk("level8_rgb", 32'({red, green, blue}), 'h742);
    frames(15);
    chk("ramp_no_done_yet", 32'(n_done), 0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("done_pulse", 32'(fade_done), 1);
    tick();
    chk("done_single", 32'(fade_done), 0);
    chk("bright_busy", 32'(fade_busy), 0);
    chk("done_count1", 32'(n_done), 1);
    chk("level16_rgb", 32'({red, green, blue}), 'hF84);
    pulse_in();
    chk("fade_in_in_bright", 32'(fade_busy), 0);
`else
    chk("first_rgb_full", 32'({red, green, blue}), 'hF84);

    pulse_out();
    pulse_in();
    frames(4);
    chk("nofade_rgb", 32'({red, green, blue}), 'hF84);
    chk("nofade_busy", 32'(fade_busy), 0);
    chk("nofade_done", 32'(fade_done), 0);
`endif

    // Datapath stream at full brightness: ranges, blanking and exact latency.
    pix(10'd0, 10'd0, 1'b0);
    repeat (3) tick();
    pix(10'd2, 10'd2, 1'b1);
    tick();
    chk("a_addr", 32'(rom_addr), 321);
    pix(10'd640, 10'd0, 1'b1);
    tick();
    chk("b_addr_xout", 32'(rom_addr), 0);
    chk("a_not_lat1", 32'({red, green, blue}), 0);
    pix(10'd10, 10'd4, 1'b0);
    tick();
    chk("a_rgb", 32'({red, green, blue}), 'hF84);
    chk("c_addr", 32'(rom_addr), 645);
    pix(10'd639, 10'd479, 1'b1);
    tick();
    chk("b_rgb_black", 32'({red, green, blue}), 0);
    chk("d_addr_corner", 32'(rom_addr), 76799);
    pix(10'd2, 10'd480, 1'b1);
    tick();
    chk("c_rgb_blanked", 32'({red, green, blue}), 0);
    chk("e_addr_yout", 32'(rom_addr), 0);
    pix(10'd10, 10'd4, 1'b1);
    tick();
    chk("d_rgb", 32'({red, green, blue}), 'hA5E);
    pix(10'd0, 10'd0, 1'b0);
    tick();
    chk("e_rgb_black", 32'({red, green, blue}), 0);
    tick();
    chk("f_rgb", 32'({red, green, blue}), 'h3C9);

    pix(10'd2, 10'd2, 1'b1);
    repeat (3) tick();
`ifdef BG_FADE_EN
    // Simultaneous commands from BRIGHT: fade_out wins.
    fade_in  = 1'b1;
    fade_out = 1'b1;
    tick();
    fade_in  = 1'b0;
    fade_out = 1'b0;
    chk("both_cmds_busy", 32'(fade_busy), 1);
    frames(10);
    chk("level11_rgb", 32'({red, green, blue}), 'hA52);
    pulse_in();
    frames(2);
    chk("reversal_level12", 32'({red, green, blue}), 'hB63);

    // Reset mid-ramp.
    reset = 1'b1;
    tick();
    chk("midreset_addr", 32'(rom_addr), 0);
    chk("midreset_rgb", 32'({red, green, blue}), 0);
    chk("midreset_busy", 32'(fade_busy), 0);
    chk("midreset_done", 32'(fade_done), 0);
    reset = 1'b0;

    pulse_in();
    frames(10);
    chk("level5_rgb", 32'({red, green, blue}), 'h421);
    frames(1);
    pulse_out();
    frames(1);
    chk("cmd_clears_cnt", 32'({red, green, blue}), 'h421);
    frames(3);
    chk("level3_rgb", 32'({red, green, blue}), 'h210);
    chk("fadeout_busy", 32'(fade_busy), 1);
    frames(6);
    chk("dark_rgb", 32'({red, green, blue}), 0);
    chk("dark_busy", 32'(fade_busy), 0);
    chk("done_count2", 32'(n_done), 2);
`else
    reset = 1'b1;
    tick();
    chk("midreset_addr", 32'(rom_addr), 0);
    chk("midreset_rgb", 32'({red, green, blue}), 0);
    reset = 1'b0;
    repeat (3) tick();
    chk("after_reset_rgb", 32'({red, green, blue}), 'hF84);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bg_fade_renderer.md
# bg_fade_renderer

Parametrised full-screen background renderer for the VGA path: it maps the current DrawX/DrawY to a source-image ROM address and scales the image by a power-of-two factor. Pixels outside the source image render black. The palette colour is brightness-modulated by a frame-stepped fade-in/fade-out controller. It sits between the VGA controller and the colour mux, and replaces the fixed per-image background modules with one reusable block driving an external ROM and palette.

## Interface
Parameters:
- SRC_W, 320, source image width in pixels
- SRC_H, 240, source image height in pixels
- SCALE_SHIFT, 1, screen-to-source shift (0 = 1:1, 1 = 2x, 2 = 4x)
- IDX_W, 4, palette index width (ROM data width)
- ADDR_W, 17, ROM address width; must hold SRC_W*SRC_H-1
- FRAMES_PER_STEP, 2, frame_tick pulses per fade level step (≥1)

Ports:
- vga_clk  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = visible region (codebase polarity)
- frame_tick  in  1  one-cycle pulse per frame, issued in vertical blanking
- fade_in  in  1  one-cycle command: ramp brightness to full
- fade_out  in  1  one-cycle command: ramp brightness to black
- rom_addr  out  ADDR_W  registered address to synchronous ROM (1-cycle read)
- rom_data  in  IDX_W  ROM output, valid 1 cycle after rom_addr
- pal_index  out  IDX_W  equals rom_data; combinational to palette
- pal_rgb  in  12  palette colour {r,g,b}, combinational from pal_index
- red, green, blue  out  4 each  registered pixel colour
- fade_busy  out  1  high while the level is ramping
- fade_done  out  1  one-cycle pulse when a ramp reaches its endpoint

## Operation
- Source coordinates: xs = DrawX >> SCALE_SHIFT, ys = DrawY >> SCALE_SHIFT. No dividers.
- in_range = (xs < SRC_W) && (ys < SRC_H). If in_range, rom_addr = ys*SRC_W + xs, truncated to ADDR_W. Otherwise rom_addr = 0.
- Pixel valid = blank && in_range, delayed to match the pipeline. An invalid pixel outputs 0,0,0.
- Colour: each channel = (c * level) >> 4, where c is the 4-bit palette channel and level is 0..16 (5 bits). Level 16 is exact passthrough; level 0 is black.
- Fade controller states:
  - DARK: level 0.
  - FADE_IN: +1 per step.
  - BRIGHT: level 16.
  - FADE_OUT: −1 per step.
- Reset state is DARK, level 0.
- fade_in moves DARK, FADE_OUT or FADE_IN to FADE_IN. It is ignored in BRIGHT.
- fade_out moves BRIGHT, FADE_IN or FADE_OUT to FADE_OUT. It is ignored in DARK.
- fade_in and fade_out in the same cycle: fade_out wins.
- A reversal mid-ramp continues from the current level; the level never jumps.
- An accepted command clears the step counter.
- The step counter advances on frame_tick in FADE_IN and FADE_OUT only. On reaching FRAMES_PER_STEP−1 it wraps to 0 and the level steps.
- Reaching 16 enters BRIGHT; reaching 0 enters DARK. Either transition pulses fade_done for 1 cycle.
- fade_busy = state is FADE_IN or FADE_OUT.

## Timing
- Edge N samples DrawX/DrawY/blank; rom_addr is valid after edge N.
- The ROM returns data after edge N+1. red/green/blue for that pixel are valid after edge N+2, so latency is 2 cycles.
- The valid bit is piped through 2 registers alongside the data.
- The level is sampled by the output stage in the same cycle. A level change takes effect on the next output register update.
- fade_done asserts in the cycle after the final frame_tick.
- Reset in the middle of an operation aborts any fade. On the cycle after reset:
  - level 0, counter 0, state DARK.
  - rom_addr 0, red/green/blue 0.
  - fade_busy 0, fade_done 0.
  - pipeline valid bits 0.

## Configuration
- BG_FADE_EN defined: fade controller present as above.
- Without BG_FADE_EN:
  - level is constant 16; images pass through at full brightness from reset.
  - fade_in, fade_out and frame_tick are ignored.
  - fade_busy and fade_done are tied 0.
  - latency is unchanged.

## Structure
- Package bg_render_pkg holds:
  - fade_state_t enum {DARK, FADE_IN, BRIGHT, FADE_OUT}
  - LEVEL_W = 5, LEVEL_MAX = 16
  - RGB_W = 4
- Sub-module bg_fade_ctrl contains the state machine, step counter, level, fade_busy and fade_done. It is instantiated only under BG_FADE_EN.
- The top level holds the address arithmetic, pipeline registers and colour scaling.

## Test plan
- Reset, SCALE_SHIFT=1, DrawX=2, DrawY=2, blank=1, BG_FADE_EN undefined -> rom_addr=321 after 1 cycle; rgb=pal_rgb two cycles after sampling.
- SRC_W=320, SCALE_SHIFT=0, DrawX=400 -> rom_addr=0 and rgb=0,0,0 at latency 2. The same pixel with blank=0 -> 0,0,0.
- BG_FADE_EN, FRAMES_PER_STEP=2, fade_in then 32 frame_ticks -> level 16, fade_done pulses once, fade_busy drops. Palette F,8,4 outputs F,8,4.
- At level 8, palette F,8,4 -> outputs 7,4,2.
- fade_in, then 10 ticks (level 5), then fade_out -> level decreases from 5 and reaches 0 after 10 more ticks; state DARK.
- fade_in and fade_out in the same cycle from BRIGHT -> FADE_OUT. Reset asserted mid-ramp -> level 0 and all outputs 0 on the next cycle.
